qsys_multi_timer: RTL and testbench



---
 rtl/qsys_multi_timer.sv | 149 ++++++++++++++
 tb/tb_qsys_multi_timer.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/qsys_multi_timer.sv
// rtl/qsys_multi_timer.sv - multi-channel prescaled interval timer, Avalon-MM slave
// Each channel has a down-counter, prescaler, one-shot/continuous mode and snapshot; irq ORs the channel interrupts.
module qsys_multi_timer #(
  parameter int NUM_CH       = 4,
  parameter int CNT_W        = 32,
  parameter int PRESCALE_W   = 8,
  parameter int RESET_PERIOD = 124999
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [5:0]        address,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  output logic              irq,
  output logic [NUM_CH-1:0] irq_vec
);
  localparam logic [CNT_W-1:0] RST_PERIOD = CNT_W'(RESET_PERIOD);

  logic [2:0]  ch_sel;
  logic [2:0]  reg_sel;
  logic        wr_en;
  logic [31:0] rd_val [NUM_CH];
  logic [31:0] readdata_d;
  logic [31:0] readdata_q;

  assign ch_sel   = address[5:3];
  assign reg_sel  = address[2:0];
  assign wr_en    = chipselect && !write_n;
  assign readdata = readdata_q;
  assign irq      = |irq_vec;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic                  wr_ch, wr_status, wr_ctrl, wr_period, wr_presc, wr_snap;
    logic                  stop, start, tick;
    logic                  to_q, to_d, run_q, run_d, ito_q, ito_d, cont_q, cont_d;
    logic [CNT_W-1:0]      period_q, period_d, count_q, count_d, snap_q, snap_d;
    logic [PRESCALE_W-1:0] presc_q, presc_d, pre_q, pre_d;
    logic [31:0]           rd_ch;

    assign wr_ch     = wr_en && (ch_sel == 3'(g));
    assign wr_status = wr_ch && (reg_sel == 3'd0);
    assign wr_ctrl   = wr_ch && (reg_sel == 3'd1);
    assign wr_period = wr_ch && (reg_sel == 3'd2);
    assign wr_presc  = wr_ch && (reg_sel == 3'd3);
    assign wr_snap   = wr_ch && (reg_sel == 3'd4);
    assign stop      = wr_ctrl && writedata[3];
    assign start     = wr_ctrl && writedata[2] && !writedata[3] && !run_q;
    // A STOP or PERIOD write in the same cycle swallows the tick entirely.
    assign tick      = run_q && (pre_q == '0) && !stop && !wr_period;
    assign irq_vec[g] = to_q && ito_q;
    assign rd_val[g]  = rd_ch;

    always_comb begin
      to_d     = to_q;
      run_d    = run_q;
      ito_d    = ito_q;
      cont_d   = cont_q;
      period_d = period_q;
      count_d  = count_q;
      snap_d   = snap_q;
      presc_d  = presc_q;
      if (run_q && (pre_q != '0)) pre_d = pre_q - PRESCALE_W'(1);
      else                        pre_d = presc_q;

      // Clear first so a timeout in the same cycle still sets TO.
      if (wr_status && writedata[0]) to_d = 1'b0;

      if (tick) begin
        if (count_q != '0) begin
          count_d = count_q - CNT_W'(1);
        end else begin
          count_d = period_q;
          to_d    = 1'b1;
          if (!cont_q) run_d = 1'b0;
        end
      end

      if (wr_ctrl) begin
        ito_d  = writedata[0];
        cont_d = writedata[1];
        if (stop)       run_d = 1'b0;
        else if (start) run_d = 1'b1;
      end

      if (wr_period) begin
        period_d = writedata[CNT_W-1:0];
        count_d  = writedata[CNT_W-1:0];
        pre_d    = presc_q;
        run_d    = 1'b0;
      end

      if (wr_presc) presc_d = writedata[PRESCALE_W-1:0];
      if (wr_snap)  snap_d  = count_q;
    end

    always_comb begin
      rd_ch = '0;
      case (reg_sel)
        3'd0:    rd_ch = {30'd0, run_q, to_q};
        3'd1:    rd_ch = {30'd0, cont_q, ito_q};
        3'd2:    rd_ch = 32'(period_q);
        3'd3:    rd_ch = 32'(presc_q);
        3'd4:    rd_ch = 32'(snap_q);
        3'd5:    rd_ch = 32'(count_q);
        3'd6:    rd_ch = 32'(irq_vec);
        default: rd_ch = '0;
      endcase
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        to_q     <= 1'b0;
        run_q    <= 1'b0;
        ito_q    <= 1'b0;
        cont_q   <= 1'b0;
        period_q <= RST_PERIOD;
        count_q  <= RST_PERIOD;
        snap_q   <= '0;
        presc_q  <= '0;
        pre_q    <= '0;
      end else begin
        to_q     <= to_d;
        run_q    <= run_d;
        ito_q    <= ito_d;
        cont_q   <= cont_d;
        period_q <= period_d;
        count_q  <= count_d;
        snap_q   <= snap_d;
        presc_q  <= presc_d;
        pre_q    <= pre_d;
      end
    end
  end

  // Unimplemented channels fall through to zero.
  always_comb begin
    readdata_d = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (ch_sel == 3'(i)) readdata_d = rd_val[i];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) readdata_q <= '0;
    else       readdata_q <= readdata_d;
  end
endmodule

// File: tb/tb_qsys_multi_timer.sv
// tb/tb_qsys_multi_timer.sv - directed self-checking bench for qsys_multi_timer
module tb_qsys_multi_timer;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [5:0]  address = '0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;
  logic        irq;
  logic [3:0]  irq_vec;

  int n_cmp = 0;
  int n_bad = 0;

  qsys_multi_timer dut (
    .clk        (clk),
    .reset      (reset),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .irq        (irq),
    .irq_vec    (irq_vec)
  );

  always #5 clk = ~clk;

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(input logic [2:0] c, input logic [2:0] r, input logic [31:0] d);
    @(negedge clk);
    address = {c, r}; chipselect = 1'b1; write_n = 1'b0; writedata = d;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic rd(input logic [2:0] c, input logic [2:0] r, output logic [31:0] d);
    @(negedge clk);
    address = {c, r}; chipselect = 1'b0; write_n = 1'b1;
    @(negedge clk);
    d = readdata;
  endtask

  task automatic test_reset();
    logic [31:0] v, exp;
    @(negedge clk);
    reset = 1'b1; chipselect = 1'b0; write_n = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    n_cmp++; if (readdata !== 32'd0) begin n_bad++; $display("FAIL reset_readdata: got %0h expected 0", readdata); end
    n_cmp++; if (irq !== 1'b0) begin n_bad++; $display("FAIL reset_irq: got %b expected 0", irq); end
    n_cmp++; if (irq_vec !== 4'b0000) begin n_bad++; $display("FAIL reset_irq_vec: got %b expected 0000", irq_vec); end
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 6; r++) begin
        rd(3'(c), 3'(r), v);
        exp = (r == 2 || r == 5) ? 32'd124999 : 32'd0;
        n_cmp++;
        if (v !== exp) begin n_bad++; $display("FAIL reset_ch%0d_reg%0d: got %0d expected %0d", c, r, v, exp); end
      end
    end
  endtask

  task automatic test_oneshot();
    logic [31:0] v;
    wr(3'd0, 3'd2, 32'd9);
    wr(3'd0, 3'd3, 32'd0);
    wr(3'd0, 3'd1, 32'h5);
    cyc(9);
    n_cmp++; if (irq !== 1'b0) begin n_bad++; $display("FAIL oneshot_irq_early: got %b expected 0", irq); end
    cyc(1);
    n_cmp++; if (irq !== 1'b1) begin n_bad++; $display("FAIL oneshot_irq: got %b expected 1", irq); end
    n_cmp++; if (irq_vec !== 4'b0001) begin n_bad++; $display("FAIL oneshot_irq_vec: got %b expected 0001", irq_vec); end
    rd(3'd0, 3'd0, v);
    n_cmp++; if (v !== 32'h1) begin n_bad++; $display("FAIL oneshot_status: got %0h expected 1", v); end
    rd(3'd0, 3'd5, v);
    n_cmp++; if (v !== 32'd9) begin n_bad++; $display("FAIL oneshot_count: got %0d expected 9", v); end
    wr(3'd0, 3'd0, 32'h1);
    wr(3'd0, 3'd1, 32'h0);
    n_cmp++; if (irq !== 1'b0) begin n_bad++; $display("FAIL oneshot_irq_clear: got %b expected 0", irq); end
  endtask

  task automatic test_continuous();
    wr(3'd2, 3'd2, 32'd3);
    wr(3'd2, 3'd3, 32'd4);
    wr(3'd2, 3'd1, 32'h6);
    address = {3'd2, 3'd0};
    cyc(20);
    n_cmp++; if (readdata !== 32'h2) begin n_bad++; $display("FAIL cont_before_k20: got %0h expected 2", readdata); end
    cyc(1);
    n_cmp++; if (readdata !== 32'h3) begin n_bad++; $display("FAIL cont_at_k20: got %0h expected 3", readdata); end
    cyc(3);
    chipselect = 1'b1; write_n = 1'b0; writedata = 32'h1;
    cyc(1);
    chipselect = 1'b0; write_n = 1'b1;
    cyc(1);
    n_cmp++; if (readdata !== 32'h2) begin n_bad++; $display("FAIL cont_cleared: got %0h expected 2", readdata); end
    cyc(13);
    chipselect = 1'b1; write_n = 1'b0; writedata = 32'h1;
    cyc(1);
    chipselect = 1'b0; write_n = 1'b1;
    cyc(1);
    n_cmp++; if (readdata !== 32'h3) begin n_bad++; $display("FAIL cont_set_wins_k40: got %0h expected 3", readdata); end
    n_cmp++; if (irq_vec !== 4'b0000) begin n_bad++; $display("FAIL cont_irq_vec: got %b expected 0000", irq_vec); end
    wr(3'd2, 3'd1, 32'h8);
    wr(3'd2, 3'd0, 32'h1);
  endtask

  task automatic test_snap_stop();
    logic [31:0] v;
    wr(3'd1, 3'd2, 32'd100);
    wr(3'd1, 3'd3, 32'd0);
    wr(3'd1, 3'd1, 32'h4);
    cyc(8);
    wr(3'd1, 3'd4, 32'd0);
    rd(3'd1, 3'd4, v);
    n_cmp++; if (v !== 32'd91) begin n_bad++; $display("FAIL snap_value: got %0d expected 91", v); end
    wr(3'd1, 3'd1, 32'hC);
    rd(3'd1, 3'd5, v);
    n_cmp++; if (v !== 32'd87) begin n_bad++; $display("FAIL stop_count: got %0d expected 87", v); end
    cyc(5);
    rd(3'd1, 3'd5, v);
    n_cmp++; if (v !== 32'd87) begin n_bad++; $display("FAIL stop_frozen: got %0d expected 87", v); end
    rd(3'd1, 3'd0, v);
    n_cmp++; if (v !== 32'h0) begin n_bad++; $display("FAIL stop_status: got %0h expected 0", v); end
  endtask

  task automatic test_period_zero();
    logic [31:0] v;
    wr(3'd1, 3'd2, 32'd0);
    wr(3'd1, 3'd1, 32'h7);
    n_cmp++; if (irq !== 1'b0) begin n_bad++; $display("FAIL p0_irq_start: got %b expected 0", irq); end
    cyc(1);
    n_cmp++; if (irq_vec !== 4'b0010) begin n_bad++; $display("FAIL p0_irq_vec: got %b expected 0010", irq_vec); end
    wr(3'd1, 3'd0, 32'h1);
    n_cmp++; if (irq !== 1'b1) begin n_bad++; $display("FAIL p0_every_cycle: got %b expected 1", irq); end
    wr(3'd1, 3'd1, 32'h8);
    wr(3'd1, 3'd0, 32'h1);
    rd(3'd1, 3'd0, v);
    n_cmp++; if (v !== 32'h0) begin n_bad++; $display("FAIL p0_stopped: got %0h expected 0", v); end
    n_cmp++; if (irq !== 1'b0) begin n_bad++; $display("FAIL p0_irq_off: got %b expected 0", irq); end
  endtask

  task automatic test_simultaneous();
    logic [31:0] v;
    wr(3'd0, 3'd2, 32'd5);
    wr(3'd2, 3'd2, 32'd3);
    wr(3'd2, 3'd3, 32'd0);
    wr(3'd0, 3'd1, 32'h5);
    wr(3'd2, 3'd1, 32'h5);
    cyc(3);
    n_cmp++; if (irq_vec !== 4'b0000) begin n_bad++; $display("FAIL simul_early: got %b expected 0000", irq_vec); end
    cyc(1);
    n_cmp++; if (irq_vec !== 4'b0101) begin n_bad++; $display("FAIL simul_irq_vec: got %b expected 0101", irq_vec); end
    n_cmp++; if (irq !== 1'b1) begin n_bad++; $display("FAIL simul_irq: got %b expected 1", irq); end
    rd(3'd1, 3'd6, v);
    n_cmp++; if (v !== 32'h5) begin n_bad++; $display("FAIL simul_pend: got %0h expected 5", v); end
    wr(3'd0, 3'd0, 32'h1);
    n_cmp++; if (irq !== 1'b1) begin n_bad++; $display("FAIL simul_one_cleared: got %b expected 1", irq); end
    n_cmp++; if (irq_vec !== 4'b0100) begin n_bad++; $display("FAIL simul_vec_one: got %b expected 0100", irq_vec); end
    wr(3'd2, 3'd0, 32'h1);
    n_cmp++; if (irq !== 1'b0) begin n_bad++; $display("FAIL simul_both_cleared: got %b expected 0", irq); end
  endtask

  task automatic test_bad_channel();
    logic [31:0] v;
    logic [31:0] exp_period [4];
    exp_period[0] = 32'd5; exp_period[1] = 32'd0; exp_period[2] = 32'd3; exp_period[3] = 32'd124999;
    wr(3'd7, 3'd2, 32'h33);
    wr(3'd0, 3'd7, 32'h44);
    rd(3'd7, 3'd2, v);
    n_cmp++; if (v !== 32'h0) begin n_bad++; $display("FAIL ch7_period: got %0h expected 0", v); end
    rd(3'd7, 3'd0, v);
    n_cmp++; if (v !== 32'h0) begin n_bad++; $display("FAIL ch7_status: got %0h expected 0", v); end
    rd(3'd0, 3'd7, v);
    n_cmp++; if (v !== 32'h0) begin n_bad++; $display("FAIL reg7_read: got %0h expected 0", v); end
    for (int c = 0; c < 4; c++) begin
      rd(3'(c), 3'd2, v);
      n_cmp++;
      if (v !== exp_period[c]) begin n_bad++; $display("FAIL bad_wr_period_ch%0d: got %0d expected %0d", c, v, exp_period[c]); end
    end
    rd(3'd3, 3'd5, v);
    n_cmp++; if (v !== 32'd124999) begin n_bad++; $display("FAIL bad_wr_count_ch3: got %0d expected 124999", v); end
  endtask

  task automatic test_reset_midcount();
    logic [31:0] v;
    wr(3'd3, 3'd1, 32'h5);
    wr(3'd0, 3'd1, 32'h7);
    cyc(20);
    n_cmp++; if (irq !== 1'b1) begin n_bad++; $display("FAIL midcount_irq_pre: got %b expected 1", irq); end
    rd(3'd3, 3'd5, v);
    n_cmp++; if (v >= 32'd124999) begin n_bad++; $display("FAIL midcount_running: got %0d expected below 124999", v); end
    test_reset();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    cyc(3);
    test_reset();
    test_oneshot();
    test_continuous();
    test_snap_stop();
    test_period_zero();
    test_simultaneous();
    test_bad_channel();
    test_reset_midcount();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
